// File: rtl/game_pkg.sv
// Shared types and constants for the BCD game timer.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        MODE_UP   = 1'b0,
        MODE_DOWN = 1'b1
    } mode_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the ripple counter: next value with carry/borrow out,
// plus the clamped form of the preset nibble.
module bcd_digit
    import game_pkg::*;
(
    input  logic       enable,
    input  mode_t      dir,
    input  logic       carry_in,
    input  logic [3:0] cur,
    input  logic [3:0] load_raw,
    output logic [3:0] next,
    output logic       carry_out,
    output logic [3:0] load_value
);

    // Step the digit when enabled and the lower digit carries/borrows into it.
    always_comb begin
        next      = cur;
        carry_out = 1'b0;
        if (enable && carry_in) begin
            if (dir == MODE_UP) begin
                if (cur >= BCD_MAX) begin
                    next      = '0;
                    carry_out = 1'b1;
                end else begin
                    next = cur + 4'd1;
                end
            end else begin
                if (cur == '0) begin
                    next      = BCD_MAX;
                    carry_out = 1'b1;
                end else begin
                    next = cur - 4'd1;
                end
            end
        end
    end

    // Non-decimal preset nibbles are clamped to 9.
    always_comb begin
        load_value = (load_raw > BCD_MAX) ? BCD_MAX : load_raw;
    end

endmodule

// File: rtl/game_timer_bcd.sv
// N-digit BCD game clock: count-up / count-down with pause, preset load,
// per-tick strobe and sticky expiry/saturation flags.
module game_timer_bcd
    import game_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned TICK_HZ = 1,
    parameter int unsigned DIGITS  = 2
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_fRun,
    input  logic                  i_fClear,
    input  logic                  i_fLoad,
    input  logic                  i_Mode,
    input  logic [4*DIGITS-1:0]   i_LoadBCD,
    output logic [4*DIGITS-1:0]   o_BCD,
    output logic                  o_fTick,
    output logic                  o_fExpired,
    output logic                  o_fSaturated
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PS_TERM = PW'(DIV - 1);

    state_t              state;
    mode_t               mode;
    mode_t               run_mode;
    logic [PW-1:0]       prescale;
    logic [4*DIGITS-1:0] count_next;
    logic [4*DIGITS-1:0] load_value;
    logic [DIGITS:0]     carry;
    logic                cur_zero;
    logic                cur_nines;
    logic                next_zero;
    logic                next_nines;
    logic                start_blocked;
    logic                advance;

    assign carry[0] = 1'b1;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .enable     (advance),
            .dir        (run_mode),
            .carry_in   (carry[k]),
            .cur        (o_BCD[4*k +: 4]),
            .load_raw   (i_LoadBCD[4*k +: 4]),
            .next       (count_next[4*k +: 4]),
            .carry_out  (carry[k+1]),
            .load_value (load_value[4*k +: 4])
        );
    end

    // Leaving IDLE uses the mode being latched on that edge; the prescaler
    // advances on every edge that runs, including the IDLE/PAUSE exit edge.
    always_comb begin
        run_mode      = (state == ST_IDLE) ? mode_t'(i_Mode) : mode;
        cur_zero      = (o_BCD == '0);
        cur_nines     = (o_BCD == {DIGITS{BCD_MAX}});
        next_zero     = (count_next == '0);
        next_nines    = (count_next == {DIGITS{BCD_MAX}});
        start_blocked = (run_mode == MODE_DOWN && cur_zero) ||
                        (run_mode == MODE_UP && cur_nines);
        advance       = i_fRun && ((state == ST_IDLE && !start_blocked) ||
                                   state == ST_RUN || state == ST_PAUSE);
    end

    // Control FSM, prescaler, count register and flags.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            state        <= ST_IDLE;
            mode         <= MODE_UP;
            prescale     <= '0;
            o_BCD        <= '0;
            o_fTick      <= 1'b0;
            o_fExpired   <= 1'b0;
            o_fSaturated <= 1'b0;
        end else begin
            o_fTick <= 1'b0;
            if (i_fClear) begin
                state        <= ST_IDLE;
                prescale     <= '0;
                o_BCD        <= '0;
                o_fExpired   <= 1'b0;
                o_fSaturated <= 1'b0;
            end else if (i_fLoad) begin
                state        <= ST_IDLE;
                prescale     <= '0;
                o_BCD        <= load_value;
                o_fExpired   <= 1'b0;
                o_fSaturated <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (i_fRun) begin
                            mode <= run_mode;
                            if (start_blocked) begin
                                state <= ST_DONE;
                                if (run_mode == MODE_DOWN) o_fExpired   <= 1'b1;
                                else                       o_fSaturated <= 1'b1;
                            end else begin
                                state <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN:   if (!i_fRun) state <= ST_PAUSE;
                    ST_PAUSE: if (i_fRun)  state <= ST_RUN;
                    default:  ;
                endcase

                // A boundary hit on a tick edge overrides the RUN transition above.
                if (advance) begin
                    if (prescale == PS_TERM) begin
                        prescale <= '0;
                        o_BCD    <= count_next;
                        o_fTick  <= 1'b1;
                        if (run_mode == MODE_UP && next_nines) begin
                            o_fSaturated <= 1'b1;
                            state        <= ST_DONE;
                        end else if (run_mode == MODE_DOWN && next_zero) begin
                            o_fExpired <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end else begin
                        prescale <= prescale + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_game_timer_bcd.sv
// Scoreboard bench for game_timer_bcd with a decimal reference model.
module tb_game_timer_bcd;

    localparam int unsigned CLK_HZ  = 10;
    localparam int unsigned TICK_HZ = 1;
    localparam int unsigned DIGITS  = 2;
    localparam int          W       = 4 * DIGITS;
    localparam int          DIV     = CLK_HZ / TICK_HZ;
    localparam int          MAXV    = 10 ** DIGITS - 1;

    typedef struct packed {
        logic [W-1:0] bcd;
        logic         tick;
        logic         expired;
        logic         saturated;
    } obs_t;

    logic         i_Clk = 1'b0;
    logic         i_Rst = 1'b0;
    logic         i_fRun = 1'b0;
    logic         i_fClear = 1'b0;
    logic         i_fLoad = 1'b0;
    logic         i_Mode = 1'b0;
    logic [W-1:0] i_LoadBCD = '0;
    logic [W-1:0] o_BCD;
    logic         o_fTick;
    logic         o_fExpired;
    logic         o_fSaturated;

    game_timer_bcd #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DIGITS(DIGITS)) dut (
        .i_Clk        (i_Clk),
        .i_Rst        (i_Rst),
        .i_fRun       (i_fRun),
        .i_fClear     (i_fClear),
        .i_fLoad      (i_fLoad),
        .i_Mode       (i_Mode),
        .i_LoadBCD    (i_LoadBCD),
        .o_BCD        (o_BCD),
        .o_fTick      (o_fTick),
        .o_fExpired   (o_fExpired),
        .o_fSaturated (o_fSaturated)
    );

    always #5 i_Clk = ~i_Clk;

    int   checks = 0;
    int   errors = 0;
    int   tick_count = 0;
    obs_t exp_q[$];

    // Reference model: count as a plain integer, sub = cycles into the current second.
    int m_val, m_sub;
    bit m_idle, m_done, m_down, m_tick, m_exp, m_sat;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd_clamped(input logic [W-1:0] b);
        int v = 0;
        int scale = 1;
        for (int k = 0; k < DIGITS; k++) begin
            int d = int'(b[4*k +: 4]);
            if (d > 9) d = 9;
            v = v + d * scale;
            scale = scale * 10;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit run, input bit clr, input bit ld,
                              input bit md, input logic [W-1:0] lv);
        m_tick = 1'b0;
        if (!rst) begin
            m_val = 0; m_sub = 0; m_idle = 1; m_done = 0; m_down = 0; m_exp = 0; m_sat = 0;
        end else if (clr) begin
            m_val = 0; m_sub = 0; m_idle = 1; m_done = 0; m_exp = 0; m_sat = 0;
        end else if (ld) begin
            m_val = from_bcd_clamped(lv); m_sub = 0; m_idle = 1; m_done = 0; m_exp = 0; m_sat = 0;
        end else if (run && !m_done) begin
            if (m_idle) begin
                m_idle = 0;
                m_down = md;
                if (m_down && m_val == 0) begin m_done = 1; m_exp = 1; end
                else if (!m_down && m_val == MAXV) begin m_done = 1; m_sat = 1; end
            end
            if (!m_done) begin
                m_sub++;
                if (m_sub == DIV) begin
                    m_sub  = 0;
                    m_tick = 1;
                    m_val  = m_down ? m_val - 1 : m_val + 1;
                    if (!m_down && m_val == MAXV) begin m_done = 1; m_sat = 1; end
                    if (m_down && m_val == 0) begin m_done = 1; m_exp = 1; end
                end
            end
        end
    endtask

    task automatic drive(input bit rst, input bit run, input bit clr, input bit ld,
                         input bit md, input logic [W-1:0] lv);
        obs_t e;
        @(negedge i_Clk);
        i_Rst = rst; i_fRun = run; i_fClear = clr; i_fLoad = ld; i_Mode = md; i_LoadBCD = lv;
        model_step(rst, run, clr, ld, md, lv);
        e.bcd = to_bcd(m_val);
        e.tick = m_tick;
        e.expired = m_exp;
        e.saturated = m_sat;
        exp_q.push_back(e);
    endtask

    task automatic run_cycles(input int n, input bit run, input bit md);
        for (int i = 0; i < n; i++) drive(1'b1, run, 1'b0, 1'b0, md, '0);
    endtask

    task automatic settle;
        @(posedge i_Clk);
        #2;
    endtask

    // Monitor: every edge with an outstanding expectation is compared.
    initial begin
        obs_t e, got;
        forever begin
            @(posedge i_Clk);
            #1;
            if (o_fTick === 1'b1) tick_count++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {o_BCD, o_fTick, o_fExpired, o_fSaturated};
                check("cycle_bcd", 32'(got.bcd), 32'(e.bcd));
                check("cycle_flags", {29'd0, got.tick, got.expired, got.saturated},
                      {29'd0, e.tick, e.expired, e.saturated});
            end
        end
    end

    initial begin
        int t0;
        model_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Reset, then 125 cycles of count-up.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        settle();
        check("reset_out", {o_BCD, o_fTick, o_fExpired, o_fSaturated}, '0);
        t0 = tick_count;
        run_cycles(125, 1'b1, 1'b0);
        settle();
        check("up_125_bcd", 32'(o_BCD), 32'h12);
        check("up_125_ticks", tick_count - t0, 12);
        check("up_125_flags", {o_fExpired, o_fSaturated}, 0);

        // Saturation from 95.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h95);
        run_cycles(40, 1'b1, 1'b0);
        settle();
        check("sat_bcd", 32'(o_BCD), 32'h99);
        check("sat_flag", o_fSaturated, 1);
        t0 = tick_count;
        run_cycles(30, 1'b1, 1'b0);
        settle();
        check("sat_hold_bcd", 32'(o_BCD), 32'h99);
        check("sat_hold_ticks", tick_count - t0, 0);

        // Count-down to expiry from 03.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03);
        run_cycles(30, 1'b1, 1'b1);
        settle();
        check("exp_bcd", 32'(o_BCD), 32'h00);
        check("exp_flag_tick", {o_fExpired, o_fTick}, 2'b11);

        // Pause holds the partial second.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        run_cycles(14, 1'b1, 1'b0);
        settle();
        check("pause_pre", 32'(o_BCD), 32'h01);
        run_cycles(50, 1'b0, 1'b1);
        settle();
        check("pause_hold", 32'(o_BCD), 32'h01);
        run_cycles(6, 1'b1, 1'b1);
        settle();
        check("resume_bcd", 32'(o_BCD), 32'h02);
        check("resume_tick", o_fTick, 1);

        // Clamped load, and count-down from zero.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA7);
        settle();
        check("load_clamp", 32'(o_BCD), 32'h97);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0);
        settle();
        check("zero_down_exp", o_fExpired, 1);
        check("zero_down_tick", o_fTick, 0);

        // Clear beats load, reset mid-count.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        run_cycles(25, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h55);
        settle();
        check("clr_ld_bcd", 32'(o_BCD), 32'h00);
        run_cycles(15, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        settle();
        check("mid_reset", {o_BCD, o_fTick, o_fExpired, o_fSaturated}, '0);

        // Randomized traffic checked against the model by the monitor.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 255) != 0), ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 127) == 0), ($urandom_range(0, 31) == 0),
                  1'($urandom), W'($urandom));
        end

        repeat (2) @(posedge i_Clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_timer_bcd.md
Name: game_timer_bcd

Overview:
- Parametrised successor to the two-digit seconds timer that drives the FND pair.
- Provides an N-digit BCD game clock with two modes:
  - count-up: elapsed play time.
  - count-down: per-level time limit.
- Also provides pause/resume, preset load, a per-tick strobe, and expiry/saturation flags.
- Sits between the game FSM (run/clear/load controls) and the FND decoders, one 4-bit digit per decoder.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 1, count rate in Hz; prescaler terminal = CLK_HZ/TICK_HZ - 1.
- DIGITS, 2, number of BCD digits (1..8); digit 0 is least significant.

Ports:
- i_Clk  input  1  system clock.
- i_Rst  input  1  reset.
- i_fRun  input  1  level: 1 = run, 0 = pause.
- i_fClear  input  1  pulse: zero count, flags, prescaler; return to IDLE.
- i_fLoad  input  1  pulse: load i_LoadBCD as the preset.
- i_Mode  input  1  0 = count-up, 1 = count-down.
- i_LoadBCD  input  4*DIGITS  preset value, digit k at [4k+3:4k].
- o_BCD  output  4*DIGITS  current count, same packing.
- o_fTick  output  1  one-cycle pulse on every count update.
- o_fExpired  output  1  sticky; count-down reached zero.
- o_fSaturated  output  1  sticky; count-up reached all nines.

Interface (already decided): one clock, i_Clk; reset i_Rst is synchronous and active-low.

Behaviour:
- Reset (i_Rst = 0 at a rising edge):
  - o_BCD = 0, o_fTick = 0, o_fExpired = 0, o_fSaturated = 0.
  - Prescaler = 0, state = IDLE, latched mode = 0.
- Control priority at each edge: reset > i_fClear > i_fLoad > run/tick logic.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - Prescaler held at 0.
  - i_fRun = 1 latches i_Mode and goes to RUN.
  - If the latched mode is count-down and o_BCD = 0: go to DONE and set o_fExpired on the same edge; no tick is generated.
- RUN:
  - Prescaler increments each cycle.
  - At terminal count it wraps to 0, and on that same edge o_BCD updates and o_fTick is registered high for exactly one cycle.
  - i_fRun = 0 goes to PAUSE.
- PAUSE:
  - Prescaler and o_BCD are held, so a resume continues the partial second.
  - i_fRun = 1 returns to RUN.
  - i_Mode is ignored; the mode is latched only on leaving IDLE.
- DONE:
  - Count, prescaler and flags are held; i_fRun is ignored.
  - Only i_fClear, i_fLoad or reset leave DONE.
- Arithmetic: per-digit BCD with ripple carry (up) or borrow (down) from digit 0 upward.
  - Up: digit 9 becomes 0 and carries.
  - Down: digit 0 becomes 9 and borrows.
- Count-up boundary: when an increment produces all nines, o_fSaturated is set and the state goes to DONE. No wrap to zero, ever.
- Count-down boundary: when a decrement produces zero, o_fExpired is set and the state goes to DONE. o_fTick still pulses for that final step.
- i_fClear: o_BCD = 0, prescaler = 0, both flags = 0, state = IDLE. This applies in any state, including mid-count.
- i_fLoad:
  - o_BCD = i_LoadBCD, with any digit > 9 clamped to 9.
  - Prescaler = 0, both flags = 0, state = IDLE.
  - Load takes effect the cycle after the pulse.
- Simultaneous events:
  - i_fClear together with i_fLoad: clear wins.
  - i_fLoad on a prescaler-terminal edge: load wins and no tick is issued.
- o_fTick is never asserted in IDLE, PAUSE or DONE.

Decomposition:
- Shared package (game_pkg):
  - State encodings: ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_DONE = 3.
  - MODE_UP = 0, MODE_DOWN = 1.
  - BCD_MAX = 9.
- One natural sub-module, bcd_digit, instantiated DIGITS times in a generate loop.
  - Inputs: enable, direction, carry/borrow in.
  - Outputs: digit, carry/borrow out.
  - Also provides the load value with clamp.

Test Plan (CLK_HZ = 10, TICK_HZ = 1, DIGITS = 2):
- Reset, then count-up run for 125 cycles -> o_BCD = 0x12, 12 single-cycle o_fTick pulses, flags 0.
- Load 0x95, count-up, run -> ticks at 0x96..0x99; at 0x99 o_fSaturated = 1 and state DONE; 30 further cycles leave 0x99 with no ticks.
- Load 0x03, count-down, run -> 0x02, 0x01, 0x00 at 10-cycle spacing; o_fExpired rises on the same edge as 0x00; last o_fTick observed.
- Count-up, pause after 14 cycles (o_BCD = 0x01, prescaler 4) for 50 cycles, resume -> o_BCD = 0x02 after 6 more run cycles.
- Load 0xA7 -> o_BCD = 0x97; count-down with 0x00 loaded and run -> o_fExpired next cycle, no tick.
- Mid-run, pulse i_fClear and i_fLoad together -> o_BCD = 0, state IDLE; i_Rst low mid-count -> all outputs 0 on the next edge.
